// File: rtl/led_anim_sequencer.sv
// led_anim_sequencer: 16-LED bar fill-up/fill-down animation controller.
// The speed switches select the frame period. In STOP (mode 0) the step
// button advances one frame per pulse.
// Optional switch debounce: define LED_ANIM_DEBOUNCE_EN.
module led_anim_sequencer #(
    parameter int unsigned NUM_LEDS   = 16,
    parameter int unsigned CNT_W      = 27,
    parameter int unsigned PER_SLOW   = 100000000,
    parameter int unsigned PER_MED    = 50000000,
    parameter int unsigned PER_FAST   = 20000000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      sw,
    input  logic                            step,
    output logic [NUM_LEDS-1:0]             led,
    output logic [$clog2(2*NUM_LEDS)-1:0]   frame_idx,
    output logic                            tick,
    output logic [1:0]                      mode
);

    localparam int unsigned      FW         = $clog2(2*NUM_LEDS);
    localparam logic [FW-1:0]    LAST_FRAME = FW'(2*NUM_LEDS-1);
    localparam logic [CNT_W-1:0] RLD_SLOW   = CNT_W'(PER_SLOW - 1);
    localparam logic [CNT_W-1:0] RLD_MED    = CNT_W'(PER_MED - 1);
    localparam logic [CNT_W-1:0] RLD_FAST   = CNT_W'(PER_FAST - 1);

    if (DEB_CYCLES < 1 || PER_FAST < 1 || PER_MED < 1 || PER_SLOW < 1 ||
        ((PER_SLOW - 1) >> CNT_W) != 0) begin : g_param_check
        $error("led_anim_sequencer: invalid period/width parameters");
    end

    typedef enum logic {STOP, RUN} state_t;

    state_t           state;
    logic [1:0]       sw_s1;
    logic [1:0]       mode_nxt;
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] reload;
    logic [FW-1:0]    frame_nxt;
    logic [NUM_LEDS-1:0] led_nxt;

    // MSB-aligned bar of lit LEDs for frame k (fill up, then empty from the LSB side)
    function automatic logic [NUM_LEDS-1:0] pattern(input logic [FW-1:0] k);
        int unsigned kk;
        int unsigned ones;
        logic [NUM_LEDS-1:0] p;
        kk   = 32'(k);
        ones = (kk <= NUM_LEDS) ? kk : 2*NUM_LEDS - kk;
        p    = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            p[NUM_LEDS-1-i] = (i < ones);
        end
        return p;
    endfunction

`ifdef LED_ANIM_DEBOUNCE_EN
    localparam int unsigned   DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [1:0]    cand;
    logic [DW-1:0] deb_cnt;

    // First sync stage, then a candidate that must stay stable before it becomes the mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1   <= '0;
            cand    <= '0;
            deb_cnt <= '0;
        end else begin
            sw_s1 <= sw;
            if (sw_s1 != cand) begin
                cand    <= sw_s1;
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_LAST) begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // Candidate is accepted on the edge that completes the stability window
    always_comb begin
        mode_nxt = mode;
        if (sw_s1 == cand && deb_cnt == DEB_LAST) begin
            mode_nxt = cand;
        end
    end
`else
    // First sync stage; the mode register is the second stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1 <= '0;
        end else begin
            sw_s1 <= sw;
        end
    end

    // Mode follows the first stage one edge later
    always_comb begin
        mode_nxt = sw_s1;
    end
`endif

    // Period reload value and next frame/pattern for the advance path
    always_comb begin
        case (mode_nxt)
            2'b01:   reload = RLD_SLOW;
            2'b10:   reload = RLD_MED;
            default: reload = RLD_FAST;
        endcase
        frame_nxt = (frame_idx == LAST_FRAME) ? '0 : frame_idx + FW'(1);
        led_nxt   = pattern(frame_nxt);
    end

    // STOP/RUN sequencer; decisions use the incoming mode so that state, mode
    // and the prescaler reload all change on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STOP;
            mode      <= '0;
            presc     <= '0;
            frame_idx <= '0;
            led       <= '0;
            tick      <= 1'b0;
        end else begin
            mode <= mode_nxt;
            tick <= 1'b0;
            if (mode_nxt == 2'b00) begin
                state <= STOP;
                presc <= '0;
                if (step) begin
                    tick      <= 1'b1;
                    frame_idx <= frame_nxt;
                    led       <= led_nxt;
                end
            end else begin
                state <= RUN;
                if (state == STOP || mode_nxt != mode) begin
                    presc <= reload;
                end else if (presc == '0) begin
                    presc     <= reload;
                    tick      <= 1'b1;
                    frame_idx <= frame_nxt;
                    led       <= led_nxt;
                end else begin
                    presc <= presc - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_anim_sequencer.sv
// Self-checking bench for led_anim_sequencer with short frame periods.
// Expected frames are queued when an advance is provoked and compared on each tick.
module tb_led_anim_sequencer;

    localparam int unsigned N  = 16;
    localparam int unsigned FW = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    sw    = 2'b00;
    logic          step  = 1'b0;
    logic [N-1:0]  led;
    logic [FW-1:0] frame_idx;
    logic          tick;
    logic [1:0]    mode;

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;
    int unsigned next_frame = 1;

    typedef struct packed {
        logic [FW-1:0] frame;
        logic [N-1:0]  led;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    led_anim_sequencer #(
        .NUM_LEDS   (16),
        .CNT_W      (8),
        .PER_SLOW   (10),
        .PER_MED    (5),
        .PER_FAST   (2),
        .DEB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .step      (step),
        .led       (led),
        .frame_idx (frame_idx),
        .tick      (tick),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_led(input int unsigned k);
        int unsigned ones;
        logic [31:0] m;
        ones = (k <= N) ? k : 2*N - k;
        m    = ((32'd1 << ones) - 32'd1) << (N - ones);
        return m[N-1:0];
    endfunction

    task automatic push_next();
        exp_t e;
        e.frame = FW'(next_frame);
        e.led   = ref_led(next_frame);
        exp_q.push_back(e);
        next_frame = (next_frame == 2*N-1) ? 0 : next_frame + 1;
    endtask

    // Counts negedges until tick is seen; n = number of clock edges waited
    task automatic wait_tick(input string tag, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < budget);
        if (!tick) check({tag, "_timeout"}, 32'(tick), 1);
    endtask

    // Scoreboard: every tick must match the oldest queued frame
    always @(negedge clk) begin
        if (rst_n && tick) begin
            tick_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_tick", 32'(tick), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("tick_frame", 32'(frame_idx), 32'(mon_e.frame));
                check("tick_led", 32'(led), 32'(mon_e.led));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        int any_mode;
        int lat;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 0);
        check("rst_frame", 32'(frame_idx), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_mode", 32'(mode), 0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_frame", 32'(frame_idx), 0);
        check("idle_led", 32'(led), 0);
        check("idle_ticks", 32'(tick_seen), 0);

        // Medium speed, full 32-frame cycle with wrap
        sw = 2'b10;
        @(negedge clk);
        check("mode_sync_1clk", 32'(mode), 0);
        @(negedge clk);
        check("mode_sync_2clk", 32'(mode), 2);
        for (int i = 0; i < 32; i++) begin
            push_next();
            wait_tick("med", 20, n);
            check("med_period", 32'(n), 5);
            if (i == 15) check("full_bar", 32'(led), 32'hFFFF);
        end
        check("wrap_frame", 32'(frame_idx), 0);
        check("wrap_led", 32'(led), 0);

        // Fast speed, then change to slow mid-count
        sw = 2'b11;
        push_next();
        wait_tick("fast_first", 20, n);
        check("fast_first_gap", 32'(n), 4);
        check("mode_fast", 32'(mode), 3);
        for (int i = 0; i < 2; i++) begin
            push_next();
            wait_tick("fast", 20, n);
            check("fast_period", 32'(n), 2);
        end
        sw = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("mode_slow", 32'(mode), 1);
        check("no_tick_on_change", 32'(tick), 0);
        for (int i = 0; i < 2; i++) begin
            push_next();
            wait_tick("slow", 30, n);
            check("slow_period", 32'(n), 10);
        end

        // STOP holds frame, step pulses advance it
        sw = 2'b00;
        repeat (100) @(negedge clk);
        check("stop_mode", 32'(mode), 0);
        check("stop_frame", 32'(frame_idx), 5);
        check("stop_led", 32'(led), 32'hF800);
        base = tick_seen;
        repeat (3) push_next();
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        #1;
        check("step_ticks", 32'(tick_seen - base), 3);
        check("step_frame", 32'(frame_idx), 8);
        check("step_led", 32'(led), 32'hFF00);

        // Step coinciding with RUN entry and step during RUN are ignored
        sw = 2'b01;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        check("entry_mode", 32'(mode), 1);
        check("step_at_entry", 32'(frame_idx), 8);
        @(negedge clk);
        step = 1'b0;
        check("step_in_run", 32'(frame_idx), 8);
        check("step_in_run_tick", 32'(tick), 0);
        push_next();
        wait_tick("slow_entry", 30, n);
        check("slow_entry_gap", 32'(n), 9);

        // Run fast up to frame 20, then asynchronous reset
        sw = 2'b11;
        for (int i = 0; i < 11; i++) begin
            push_next();
            wait_tick("fast_run", 20, n);
            check("fast_run_gap", 32'(n), (i == 0) ? 4 : 2);
        end
        check("pre_reset_frame", 32'(frame_idx), 20);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 0);
        check("async_rst_frame", 32'(frame_idx), 0);
        check("async_rst_tick", 32'(tick), 0);
        check("async_rst_mode", 32'(mode), 0);
        check("queue_drained", 32'(exp_q.size()), 0);
        next_frame = 1;
        sw = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Short switch glitch
        any_mode = 0;
        sw = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mode != 2'b00) any_mode = 1;
        end
        sw = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mode != 2'b00) any_mode = 1;
        end
`ifdef LED_ANIM_DEBOUNCE_EN
        check("glitch_blocked", 32'(any_mode), 0);
        lat = 6;
`else
        check("glitch_passed", 32'(any_mode), 1);
        lat = 2;
`endif
        check("glitch_settled", 32'(mode), 0);

        // Stable switch change latency
        sw = 2'b10;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i == lat - 1) check("stable_before", 32'(mode), 0);
        end
        check("stable_after", 32'(mode), 2);
        rst_n = 1'b0;
        #1;
        check("final_rst_mode", 32'(mode), 0);
        check("final_queue", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
